sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock FIFO: the same-clock successor to our dual-clock fifo, for paths where producer and consumer share a clock.
//  Parametrised data width and depth; registered full/empty flags plus almost-full/almost-empty thresholds.
//  Also provides a fill-level count and sticky overflow/underflow error flags.
//  Read mode (registered or first-word-fall-through) is selected at compile time.
// PARAMETERS
//  DSIZE       8   data word width in bits
//  ASIZE       4   address width; DEPTH = 2**ASIZE words
//  AFULL_LVL   12  awfull asserts when level >= AFULL_LVL (1..DEPTH)
//  AEMPTY_LVL  2   arempty asserts when level <= AEMPTY_LVL (0..AFULL_LVL-1)
// PORTS
//  clk        in   1        single clock, all logic rising-edge
//  rst        in   1        synchronous, active-high reset
//  winc       in   1        write request
//  wdata      in   DSIZE    write data
//  wfull      out  1        FIFO holds DEPTH words
//  awfull     out  1        level >= AFULL_LVL
//  rinc       in   1        read request
//  rdata      out  DSIZE    read data (timing per CONFIGURATION)
//  rempty     out  1        FIFO holds 0 words
//  arempty    out  1        level <= AEMPTY_LVL
//  level      out  ASIZE+1  current word count, 0..DEPTH
//  overflow   out  1        sticky: a write was attempted while wfull
//  underflow  out  1        sticky: a read was attempted while rempty
// BEHAVIOUR
//  - Reset (rst=1 at edge):
//    - wptr=rptr=0, level=0, rempty=1, arempty=1, wfull=0, awfull=0, overflow=underflow=0, rdata=0.
//    - Memory contents are not reset.
//  - Pointers: ASIZE+1 bits and wrap naturally; memory is indexed by the low ASIZE bits.
//  - Write accept: we = winc & ~wfull; read accept: re = rinc & ~rempty; both use flag values sampled at cycle start.
//  - level_next = level + we - re; all flags are registered from level_next and are valid in the cycle after the edge.
//  - wfull = (level==DEPTH); rempty = (level==0).
//  - Simultaneous we & re: level unchanged; the read returns the old head, never the word being written.
//  - Full & winc & rinc: read accepted, write rejected, overflow set; level -> DEPTH-1.
//  - Empty & winc & rinc: write accepted, read rejected, underflow set; level -> 1.
//  - Rejected write: memory and pointers untouched. Rejected read: rptr and rdata untouched.
//  - overflow/underflow stay set until rst; only rst clears them.
//  - Reset mid-operation: all in-flight contents are discarded; the first write after reset is the first read.
//  - Words are read out strictly in write order across pointer wrap.
// CONFIGURATION
//  Macro SYNC_FIFO_FWFT_EN.
//  - Undefined (registered read): rdata is loaded from mem[rptr] on the edge where re=1.
//    - Data is valid the cycle after the read is accepted (latency 1); rdata holds between reads.
//  - Defined (first-word-fall-through): rdata = mem[rptr] combinationally whenever rempty=0 (latency 0).
//    - rinc acknowledges and pops the head.
//    - A word written into an empty FIFO at edge k is visible on rdata in the same cycle rempty falls after edge k.
//    - rdata is don't-care while rempty=1.
//  - All flag, level and error behaviour is identical in both modes.
// TESTING (DSIZE=8, ASIZE=4, AFULL_LVL=12, AEMPTY_LVL=2; every test in both macro settings)
//  1. Reset, then write 0x00..0x0F -> awfull rises after 12th write, wfull after 16th, level=16, rempty=0.
//  2. Full FIFO, 17th write 0xAA -> overflow=1, level=16; drain -> rdata 0x00..0x0F in order, 0xAA never read.
//  3. Level 5, winc & rinc for 10 cycles -> level stays 5, outputs continue in write order, no error flags.
//  4. Stream 40 words 0x00..0x27 at level <= 3 (pointer wrap) -> exact in-order output; arempty tracks level <= 2.
//  5. Empty FIFO, rinc alone -> underflow=1; winc & rinc together -> level=1, data readable next cycle.
//  6. Level 9, assert rst for one cycle mid-stream -> next cycle level=0, rempty=1, flags cleared; next write 0x5C reads back first.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, fill level and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module sync_fifo_flags #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] DEPTH_L  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_L  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AEMPTY_L = (ASIZE+1)'(AEMPTY_LVL);

  logic [DEPTH-1:0][DSIZE-1:0] mem;
  logic [ASIZE:0]              wptr, rptr, level_next;
  logic                        we, re;

  // Accepts use the registered flags from the start of the cycle.
  assign we = winc & ~wfull;
  assign re = rinc & ~rempty;

  always_comb begin
    level_next = level;
    if (we && !re)      level_next = level + ONE;
    else if (re && !we) level_next = level - ONE;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      wfull     <= 1'b0;
      awfull    <= 1'b0;
      rempty    <= 1'b1;
      arempty   <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we) wptr <= wptr + ONE;
      if (re) rptr <= rptr + ONE;
      level     <= level_next;
      wfull     <= (level_next == DEPTH_L);
      awfull    <= (level_next >= AFULL_L);
      rempty    <= (level_next == '0);
      arempty   <= (level_next <= AEMPTY_L);
      overflow  <= overflow  | (winc & wfull);
      underflow <= underflow | (rinc & rempty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented as soon as rempty drops; rinc pops it.
  assign rdata = mem[rptr[ASIZE-1:0]];
`else
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[rptr[ASIZE-1:0]];
  end
`endif

endmodule
